ysyx_24090018_core_ctrl: RTL and testbench

- Multi-cycle sequencer for the JX500 core: PC register, IDU, EXU and RegisterFile.
- Fetches each instruction from the instruction memory over a valid/ready request and valid response handshake, and holds it in an instruction register for IDU/EXU.
- Gates the register-file write enable and the PC update to a single writeback cycle per instruction.
- Detects ebreak (halt) and fetch faults (error), and counts retired instructions.

---
 rtl/ysyx_24090018_core_ctrl.sv | 106 ++++++++++
 tb/tb_ysyx_24090018_core_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090018_core_ctrl.sv
// ysyx_24090018_core_ctrl: multi-cycle fetch/exec/writeback sequencer with halt, fault detection and a retire counter
module ysyx_24090018_core_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_WIDTH-1:0] EBREAK_INST = 32'h00100073
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run_i,
  output logic                  ifu_req_valid_o,
  input  logic                  ifu_req_ready_i,
  input  logic                  ifu_rsp_valid_i,
  input  logic                  ifu_rsp_err_i,
  input  logic [DATA_WIDTH-1:0] ifu_rsp_data_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  inst_valid_o,
  input  logic                  rf_we_i,
  output logic                  rf_we_o,
  output logic                  pc_we_o,
  output logic                  halt_o,
  output logic                  err_o,
  output logic [CNT_WIDTH-1:0]  retired_cnt_o,
  output logic [2:0]            state_o
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    EXEC       = 3'd3,
    WB         = 3'd4,
    HALT       = 3'd5,
    ERROR      = 3'd6
  } state_t;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [TW-1:0] tcnt, tcnt_n, tcnt_inc;
  logic [DATA_WIDTH-1:0] inst_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic halt_n, err_n;
  assign tcnt_inc = tcnt + TW'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tcnt <= '0;
      inst_o <= '0;
      retired_cnt_o <= '0;
      halt_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_n;
      tcnt <= tcnt_n;
      inst_o <= inst_n;
      retired_cnt_o <= cnt_n;
      halt_o <= halt_n;
      err_o <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    tcnt_n = tcnt;
    inst_n = inst_o;
    cnt_n = retired_cnt_o;
    halt_n = halt_o;
    err_n = err_o;
    case (state)
      IDLE: state_n = run_i ? FETCH_REQ : IDLE;
      FETCH_REQ: begin
        state_n = ifu_req_ready_i ? FETCH_WAIT : FETCH_REQ;
        tcnt_n = ifu_req_ready_i ? '0 : tcnt;
      end
      FETCH_WAIT: begin
        // a response in the final wait cycle takes priority over the timeout
        if (ifu_rsp_valid_i) begin
          state_n = ifu_rsp_err_i ? ERROR : EXEC;
          err_n = err_o | ifu_rsp_err_i;
          inst_n = ifu_rsp_err_i ? inst_o : ifu_rsp_data_i;
        end else if (tcnt_inc == TW'(TIMEOUT)) begin
          state_n = ERROR;
          err_n = 1'b1;
        end else begin
          tcnt_n = tcnt_inc;
        end
      end
      EXEC: begin
        state_n = (inst_o == EBREAK_INST) ? HALT : WB;
        halt_n = halt_o | (inst_o == EBREAK_INST);
        cnt_n = (inst_o == EBREAK_INST) ? retired_cnt_o + CNT_WIDTH'(1) : retired_cnt_o;
      end
      WB: begin
        state_n = FETCH_REQ;
        cnt_n = retired_cnt_o + CNT_WIDTH'(1);
      end
      HALT, ERROR: state_n = state;
      default: begin
        state_n = ERROR;
        err_n = 1'b1;
      end
    endcase
  end
  assign state_o = state;
  assign ifu_req_valid_o = state == FETCH_REQ;
  assign inst_valid_o = state == EXEC || state == WB;
  assign rf_we_o = state == WB && rf_we_i;
  assign pc_we_o = state == WB;
endmodule

// File: tb/tb_ysyx_24090018_core_ctrl.sv
// tb_ysyx_24090018_core_ctrl: scoreboard bench; retirements are queued by the stimulus and checked by a monitor on each pc_we_o pulse
module tb_ysyx_24090018_core_ctrl;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run_i = 1'b0;
  logic req_ready = 1'b0;
  logic rsp_valid = 1'b0;
  logic rsp_err = 1'b0;
  logic rf_we_i = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic ifu_req_valid_o, inst_valid_o, rf_we_o, pc_we_o, halt_o, err_o;
  logic [DW-1:0] inst_o;
  logic [CW-1:0] retired_cnt_o;
  logic [2:0] state_o;

  ysyx_24090018_core_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run_i(run_i),
    .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_ready_i(req_ready),
    .ifu_rsp_valid_i(rsp_valid), .ifu_rsp_err_i(rsp_err), .ifu_rsp_data_i(rsp_data),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o),
    .rf_we_i(rf_we_i), .rf_we_o(rf_we_o), .pc_we_o(pc_we_o),
    .halt_o(halt_o), .err_o(err_o), .retired_cnt_o(retired_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] inst;
    logic          we;
    logic [CW-1:0] cnt;
    int            gap;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int mcyc = 0;
  int last = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic we, input logic [CW-1:0] c, input int g);
    exp_t e;
    e.inst = d;
    e.we = we;
    e.cnt = c;
    e.gap = g;
    q.push_back(e);
  endtask

  // monitor: strobes only in WB, and every pc_we_o pulse must match the next queued retirement
  initial forever begin
    @(negedge clk);
    mcyc++;
    if (!rst) begin
      if (state_o != 3'd4) chk("strobe_outside_wb", {30'd0, rf_we_o, pc_we_o}, 32'd0);
      if (pc_we_o) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: inst %0h with empty queue at %0t", inst_o, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_inst", inst_o, e.inst);
          chk("wb_rf_we", {31'd0, rf_we_o}, {31'd0, e.we});
          chk("wb_cnt", {30'd0, retired_cnt_o}, {30'd0, e.cnt});
          chk("wb_inst_valid", {31'd0, inst_valid_o}, 32'd1);
          if (e.gap != 0) chk("retire_gap", mcyc - last, e.gap);
        end
        last = mcyc;
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (ifu_req_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, ifu_req_valid_o}, 32'd1);
  endtask

  // memory model: hold ready low rdly cycles, respond in the wdly-th wait cycle
  task automatic fetch(input logic [DW-1:0] d, input logic e, input int rdly, input int wdly, input logic we);
    wait_req();
    rf_we_i = we;
    req_ready = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("req_held", {31'd0, ifu_req_valid_o}, 32'd1);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    repeat (wdly - 1) @(negedge clk);
    rsp_valid = 1'b1;
    rsp_err = e;
    rsp_data = d;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_err = 1'b0;
    rsp_data = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_req_valid", {31'd0, ifu_req_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_flags", {26'd0, inst_valid_o, rf_we_o, pc_we_o, halt_o, err_o}, 32'd0);
    chk("rst_cnt", {30'd0, retired_cnt_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold", {29'd0, state_o}, 32'd0);
    run_i = 1'b1;
    push(32'h00500093, 1'b1, 2'd0, 0);
    fetch(32'h00500093, 1'b0, 0, 1, 1'b1);
    push(32'h00a00113, 1'b1, 2'd1, 4);
    fetch(32'h00a00113, 1'b0, 0, 1, 1'b1);
    push(32'h002081b3, 1'b1, 2'd2, 4);
    fetch(32'h002081b3, 1'b0, 0, 1, 1'b1);
    wait_req();
    chk("cnt_after_3", {30'd0, retired_cnt_o}, 32'd3);
    push(32'h00000013, 1'b0, 2'd3, 10);
    fetch(32'h00000013, 1'b0, 3, 4, 1'b0);
    push(32'h40208233, 1'b1, 2'd0, 4);
    fetch(32'h40208233, 1'b0, 0, 1, 1'b1);
    wait_req();
    chk("cnt_wrap", {30'd0, retired_cnt_o}, 32'd1);
    fetch(32'h00100093, 1'b0, 0, 1, 1'b1);
    @(posedge clk);
    #1;
    chk("midwb_state", {29'd0, state_o}, 32'd4);
    chk("midwb_strobes", {30'd0, rf_we_o, pc_we_o}, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_state", {29'd0, state_o}, 32'd0);
    chk("async_rst_strobes", {30'd0, rf_we_o, pc_we_o}, 32'd0);
    chk("async_rst_cnt", {30'd0, retired_cnt_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    fetch(32'h00100073, 1'b0, 0, 1, 1'b1);
    chk("ebreak_exec", {29'd0, state_o}, 32'd3);
    chk("ebreak_halt_pre", {31'd0, halt_o}, 32'd0);
    @(negedge clk);
    chk("ebreak_state", {29'd0, state_o}, 32'd5);
    chk("ebreak_halt", {31'd0, halt_o}, 32'd1);
    chk("ebreak_cnt", {30'd0, retired_cnt_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      run_i = ~run_i;
      @(negedge clk);
      chk("halt_stays", {28'd0, halt_o, state_o}, 32'hd);
    end
    do_reset();
    run_i = 1'b1;
    push(32'h00300193, 1'b1, 2'd0, 0);
    fetch(32'h00300193, 1'b0, 0, 1, 1'b1);
    fetch(32'hdeadbeef, 1'b1, 0, 1, 1'b0);
    chk("rsp_err_state", {29'd0, state_o}, 32'd6);
    chk("rsp_err_flag", {30'd0, halt_o, err_o}, 32'd1);
    chk("rsp_err_inst_kept", inst_o, 32'h00300193);
    @(negedge clk);
    chk("err_stays", {28'd0, ifu_req_valid_o, state_o}, 32'd6);
    do_reset();
    wait_req();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    for (int i = 0; i < TO; i++) begin
      chk("to_waiting", {28'd0, err_o, state_o}, 32'd2);
      @(negedge clk);
    end
    chk("to_state", {29'd0, state_o}, 32'd6);
    chk("to_err", {31'd0, err_o}, 32'd1);
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule
